sbus_frame_decoder: RTL
=======================

Name: sbus_frame_decoder

Overview:
- Downstream consumer of the S-Bus UART byte receiver (100 kBit/s, 8E2, inverted line, byte strobe plus sticky error).
- Assembles 25-byte S-Bus frames: header 0x0F, 22 payload bytes, 1 flags byte, 1 footer byte.
- Unpacks the payload into 16 channels of 11 bits each and presents them with the flag bits and a one-cycle frame-valid strobe to the flight-control logic.
- Detects broken frames (bad footer, mid-frame gap) and resynchronises on the inter-frame gap.

Parameters:
- GAP_TICKS, 50000, clk_i cycles without a byte strobe that mark an inter-frame gap (500 us at 100 MHz).
- CNT_W, 8, width of the saturating frame-error counter.

Ports:
- clk_i  in  1  clock, 100 MHz nominal.
- rst_ni  in  1  reset, asynchronous, active-low.
- data_i  in  8  received byte; valid only in the rdy_i cycle.
- rdy_i  in  1  one-cycle byte strobe from the UART.
- err_i  in  1  sticky UART error (level).
- channels_o  out  176  ch0 at [10:0], chN at [11N+10:11N].
- ch17_o  out  1  digital channel 17.
- ch18_o  out  1  digital channel 18.
- frame_lost_o  out  1  frame-lost flag.
- failsafe_o  out  1  failsafe flag.
- valid_o  out  1  one-cycle strobe: outputs were updated.
- frame_err_o  out  1  one-cycle strobe: frame discarded.
- err_cnt_o  out  CNT_W  saturating count of discarded frames.

Behaviour:
- Reset values:
  - All outputs 0.
  - State HEADER.
  - Gap timer preset to GAP_TICKS (saturated), so the first header after reset is accepted.
  - Payload buffer 0; byte index 0.
- Gap timer:
  - Cleared to 0 on any rdy_i.
  - Otherwise increments, saturating at GAP_TICKS.
  - "gap" = (timer == GAP_TICKS), evaluated before the clear in that cycle.
- State HEADER:
  - On rdy_i with data_i == 0x0F and gap: go to PAYLOAD, index = 0.
  - Any other byte is ignored silently; no error, no count.
- State PAYLOAD:
  - On rdy_i, store data_i into buffer byte[index] and increment index (5 bits).
  - The byte stored at index 22 is the flags byte; after it, go to FOOTER.
- State FOOTER:
  - On rdy_i, data_i in {0x00, 0x04, 0x14, 0x24, 0x34} is accepted.
  - Accept: on the next edge, load the outputs from the buffer, pulse valid_o, go to HEADER.
  - Reject: on the next edge, pulse frame_err_o, increment err_cnt_o (saturating at all-ones), go to HEADER; outputs are held.
- Latency: valid_o and the new outputs appear exactly 1 cycle after the footer rdy_i cycle.
- Mid-frame gap: in PAYLOAD or FOOTER, if the timer reaches GAP_TICKS, abort.
  - frame_err_o pulses and err_cnt_o increments once.
  - State goes to HEADER, index = 0, outputs held.
  - The timer is saturated, so a 0x0F header arriving immediately afterwards is accepted.
- Unpacking:
  - The payload is a 176-bit little-endian stream: buffer byte k occupies stream bits [8k+7:8k].
  - channels_o equals that stream directly.
  - Flags byte: bit0 = ch17, bit1 = ch18, bit2 = frame_lost, bit3 = failsafe; bits 7:4 ignored.
- err_i high, level-sensitive and checked every cycle:
  - Force HEADER, index = 0; ignore rdy_i.
  - No valid_o; outputs held.
  - frame_err_o pulses once only if it interrupts PAYLOAD or FOOTER, with err_cnt_o incrementing once.
  - Normal operation resumes when err_i drops.
- Simultaneous events:
  - rdy_i in the cycle the timer reaches GAP_TICKS while in PAYLOAD or FOOTER: the byte wins. It is processed normally and the timer clears.
  - err_i together with rdy_i: err_i wins.
- valid_o and frame_err_o are never high in the same cycle. Each pulse is exactly one cycle wide.
- Reset mid-frame: everything returns to the reset values immediately; no strobes are generated.

Test Plan:
- Good frame, all channels = 0x400: header 0x0F, 22 payload bytes, flags 0x0C, footer 0x00, byte strobes 12000 cycles apart.
  -> 1 cycle after the footer strobe, valid_o pulses.
  -> Every 11-bit channel field = 0x400; failsafe_o = 1, frame_lost_o = 1, ch17_o = 0, ch18_o = 0; err_cnt_o = 0.
- Distinct channel values: ch0 = 0x7FF, ch15 = 0x001, others 0; footer 0x14.
  -> channels_o[10:0] = 0x7FF, channels_o[175:165] = 0x001, all other bits 0; valid_o pulses.
- Bad footer 0x55 after a valid frame.
  -> frame_err_o pulses, err_cnt_o = 1, no valid_o, all outputs hold the previous frame.
- Mid-frame gap: 10 payload bytes, then silence for GAP_TICKS cycles, then a full good frame.
  -> One frame_err_o pulse; err_cnt_o increments by 1.
  -> The following frame is decoded and valid_o pulses.
- Resync: 0x0F sent within GAP_TICKS of the previous byte while in HEADER -> ignored, no strobes; the same byte after the gap -> frame accepted.
- err_i asserted at payload byte 5, released later, then a good frame.
  -> One frame_err_o pulse while asserted.
  -> Bytes during err_i are ignored; the good frame after release is decoded normally.
- Counter saturation: with CNT_W = 2, four bad frames -> err_cnt_o stays at 3.

Source files
------------

// File: rtl/sbus_frame_decoder.sv
// S-Bus frame decoder: 25-byte frames -> 16x11-bit channels, flags, valid/error strobes.
// Latency 1 cycle after the footer strobe; no backpressure, bytes arrive as one-cycle strobes.
module sbus_frame_decoder #(
  parameter int GAP_TICKS = 50000,
  parameter int CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       data_i,
  input  logic             rdy_i,
  input  logic             err_i,
  output logic [175:0]     channels_o,
  output logic             ch17_o,
  output logic             ch18_o,
  output logic             frame_lost_o,
  output logic             failsafe_o,
  output logic             valid_o,
  output logic             frame_err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int TW = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {
    S_HEADER,
    S_PAYLOAD,
    S_FOOTER
  } state_t;

  state_t           state_q;
  logic [TW-1:0]    timer_q;
  logic [21:0][7:0] pay_q;
  logic [3:0]       flags_q;
  logic [4:0]       idx_q;
  logic             gap;
  logic             footer_ok;

  assign gap = (timer_q == TW'(GAP_TICKS));

  always_comb begin
    footer_ok = 1'b0;
    case (data_i)
      8'h00, 8'h04, 8'h14, 8'h24, 8'h34: footer_ok = 1'b1;
      default:                           footer_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_HEADER;
      timer_q      <= TW'(GAP_TICKS);
      pay_q        <= '0;
      flags_q      <= '0;
      idx_q        <= '0;
      channels_o   <= '0;
      ch17_o       <= 1'b0;
      ch18_o       <= 1'b0;
      frame_lost_o <= 1'b0;
      failsafe_o   <= 1'b0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;

      if (rdy_i)     timer_q <= '0;
      else if (!gap) timer_q <= timer_q + TW'(1);

      // A UART error drops any partial frame; only an interrupted frame is counted.
      if (err_i) begin
        state_q <= S_HEADER;
        idx_q   <= '0;
        if (state_q != S_HEADER) begin
          frame_err_o <= 1'b1;
          if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
        end
      end else begin
        case (state_q)
          S_HEADER: begin
            if (rdy_i && data_i == 8'h0F && gap) begin
              state_q <= S_PAYLOAD;
              idx_q   <= '0;
            end
          end
          S_PAYLOAD: begin
            if (rdy_i) begin
              idx_q <= idx_q + 5'd1;
              if (idx_q == 5'd22) begin
                flags_q <= data_i[3:0];
                state_q <= S_FOOTER;
              end else begin
                pay_q[idx_q] <= data_i;
              end
            end else if (gap) begin
              state_q     <= S_HEADER;
              idx_q       <= '0;
              frame_err_o <= 1'b1;
              if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
            end
          end
          S_FOOTER: begin
            if (rdy_i) begin
              state_q <= S_HEADER;
              idx_q   <= '0;
              if (footer_ok) begin
                channels_o   <= pay_q;
                ch17_o       <= flags_q[0];
                ch18_o       <= flags_q[1];
                frame_lost_o <= flags_q[2];
                failsafe_o   <= flags_q[3];
                valid_o      <= 1'b1;
              end else begin
                frame_err_o <= 1'b1;
                if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
              end
            end else if (gap) begin
              state_q     <= S_HEADER;
              idx_q       <= '0;
              frame_err_o <= 1'b1;
              if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
            end
          end
          default: begin
            state_q <= S_HEADER;
            idx_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule
